// File: rtl/uart_rx_byte.sv
`timescale 1ns/1ps
// uart_rx_byte: 8-N-1 UART receiver, oversampled by the system clock.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   rx_in      - raw UART line (idle high), asynchronous to clk
//   data       - last good byte, held until the next good byte
//   data_valid - one-cycle pulse when data has just been updated
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   busy       - high while a frame (or a break) is in progress
module uart_rx_byte #(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 115200,
  parameter int unsigned CPB      = CLK_FREQ / BAUD,
  parameter int unsigned HALF     = CPB / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);

  typedef enum logic [2:0] {
    S_WAIT_HIGH,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bitn, bitn_n;
  logic [7:0]       sh, sh_n;
  logic [7:0]       data_n;
  logic             data_valid_n, frame_err_n, busy_n;
  logic             rx_m, rx_s;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_WAIT_HIGH;
      cnt        <= '0;
      bitn       <= '0;
      sh         <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      bitn       <= bitn_n;
      sh         <= sh_n;
      data       <= data_n;
      data_valid <= data_valid_n;
      frame_err  <= frame_err_n;
      busy       <= busy_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    bitn_n       = bitn;
    sh_n         = sh;
    data_n       = data;
    data_valid_n = 1'b0;
    frame_err_n  = 1'b0;

    case (state)
      // A line held low at reset release must not be mistaken for a start bit.
      S_WAIT_HIGH: begin
        if (rx_s) state_n = S_IDLE;
      end

      S_IDLE: begin
        if (!rx_s) begin
          state_n = S_START;
          cnt_n   = '0;
        end
      end

      // Re-check the line at the start-bit centre to reject glitches.
      S_START: begin
        if (cnt == CNT_MID) begin
          cnt_n = '0;
          if (!rx_s) begin
            state_n = S_DATA;
            bitn_n  = '0;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      // LSB first: new bit enters at the top and the register shifts right.
      S_DATA: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          sh_n  = {rx_s, sh[7:1]};
          if (bitn == 3'd7) begin
            state_n = S_STOP;
          end else begin
            bitn_n = bitn + 3'd1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      // Leaving at the stop-bit centre lets a back-to-back start bit be seen.
      S_STOP: begin
        if (cnt == CNT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            data_n       = sh;
            data_valid_n = 1'b1;
            state_n      = S_IDLE;
          end else begin
            frame_err_n = 1'b1;
            state_n     = S_BREAK;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end

      S_BREAK: begin
        if (rx_s) state_n = S_IDLE;
      end

      default: begin
        state_n = S_WAIT_HIGH;
        cnt_n   = '0;
      end
    endcase

    // Registered from the next state so busy drops with the result pulse.
    busy_n = (state_n == S_START) || (state_n == S_DATA) ||
             (state_n == S_STOP)  || (state_n == S_BREAK);
  end

endmodule

// File: tb/tb_uart_rx_byte.sv
`timescale 1ns/1ps
// Self-checking bench for uart_rx_byte at CPB=10, HALF=5.
module tb_uart_rx_byte;

  localparam int LAT = 2 + 5 + 9 * 10;  // E0 to result edge

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [7:0] data;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  uart_rx_byte #(
    .CLK_FREQ(1_000_000),
    .BAUD    (100_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_in     (rx_in),
    .data      (data),
    .data_valid(data_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Observed pulses (written only by the monitor).
  int obs_kind[$];
  int obs_data[$];
  int obs_cyc[$];
  int busy_cnt = 0;
  bit prev_pulse = 1'b0;

  // Expected pulses (written only by the stimulus process).
  int exp_kind[$];
  int exp_data[$];
  int exp_cyc[$];
  int rd = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Monitor: record every pulse, check exclusivity and single-cycle width.
  always @(negedge clk) begin
    if (rst) begin
      prev_pulse <= 1'b0;
    end else begin
      if (busy) busy_cnt <= busy_cnt + 1;
      if (data_valid || frame_err) begin
        chk("pulse_excl", 32'(data_valid & frame_err), 32'd0);
        chk("pulse_consec", 32'(prev_pulse), 32'd0);
        obs_kind.push_back(data_valid ? 1 : 0);
        obs_data.push_back(int'(data));
        obs_cyc.push_back(cyc);
      end
      prev_pulse <= data_valid | frame_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) tick();
  endtask

  // Drive one frame; p10 is the bit period in tenths of a clock (floor-dithered).
  task automatic send_frame(input logic [7:0] b, input int p10, input bit stop_ok,
                            input int extra_low, input int abort_bit);
    logic [9:0] bits;
    int n;
    int e0;
    bit aborted;
    bits    = {stop_ok, b, 1'b0};
    e0      = 0;
    aborted = 1'b0;
    for (int i = 0; i < 10; i++) begin
      n = ((i + 1) * p10) / 10 - (i * p10) / 10;
      for (int j = 0; j < n; j++) begin
        rx_in = bits[i];
        if (i == 0 && j == 0) e0 = cyc + 1;
        if (i == abort_bit && j == n / 2) begin
          rst = 1'b1;
          #1;
          chk("rst_data", 32'(data), 32'd0);
          chk("rst_valid", 32'(data_valid), 32'd0);
          chk("rst_ferr", 32'(frame_err), 32'd0);
          chk("rst_busy", 32'(busy), 32'd0);
          @(posedge clk);
          #1;
          rst     = 1'b0;
          rx_in   = 1'b1;
          aborted = 1'b1;
          break;
        end
        tick();
      end
      if (aborted) break;
    end
    if (aborted) begin
      last_good = 8'h00;
      return;
    end
    if (!stop_ok) begin
      rx_in = 1'b0;
      repeat (extra_low) tick();
      rx_in = 1'b1;
    end
    if (stop_ok) begin
      exp_kind.push_back(1);
      exp_data.push_back(int'(b));
      last_good = b;
    end else begin
      exp_kind.push_back(0);
      exp_data.push_back(int'(last_good));
    end
    exp_cyc.push_back(e0 + LAT);
  endtask

  // Compare everything observed since the last drain against the model.
  task automatic drain(input string tag);
    int n_obs;
    int n;
    n_obs = obs_kind.size() - rd;
    chk({tag, "_count"}, 32'(n_obs), 32'(exp_kind.size()));
    n = (n_obs < exp_kind.size()) ? n_obs : exp_kind.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_kind"}, 32'(obs_kind[rd + i]), 32'(exp_kind[i]));
      chk({tag, "_data"}, 32'(obs_data[rd + i]), 32'(exp_data[i]));
      chk({tag, "_cycle"}, 32'(obs_cyc[rd + i]), 32'(exp_cyc[i]));
    end
    rd = obs_kind.size();
    exp_kind.delete();
    exp_data.delete();
    exp_cyc.delete();
  endtask

  initial begin
    logic [7:0] hello[5];
    logic [7:0] pat[3];
    int b0;
    hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};
    pat   = '{8'h00, 8'hFF, 8'h81};

    rst   = 1'b1;
    rx_in = 1'b1;
    repeat (3) tick();
    chk("reset_data", 32'(data), 32'h00);
    chk("reset_valid", 32'(data_valid), 32'd0);
    chk("reset_ferr", 32'(frame_err), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    idle(10);

    // 1: single ideal frame, exact latency and busy window
    b0 = busy_cnt;
    send_frame(8'h48, 100, 1'b1, 0, -1);
    idle(20);
    drain("t1");
    chk("t1_busy_cycles", 32'(busy_cnt - b0), 32'd95);

    // 2: "Hello" back-to-back
    foreach (hello[i]) send_frame(hello[i], 100, 1'b1, 0, -1);
    idle(20);
    drain("t2");
    chk("t2_data_hold", 32'(data), 32'h6F);

    // 3: short glitch, then a real frame
    rx_in = 1'b0;
    repeat (3) tick();
    idle(15);
    chk("t3_glitch_busy", 32'(busy), 32'd0);
    drain("t3_glitch");
    send_frame(8'h55, 100, 1'b1, 0, -1);
    idle(20);
    drain("t3");

    // 4: framing error with an extended break
    send_frame(8'hA5, 100, 1'b0, 40, -1);
    idle(5);
    chk("t4_data_kept", 32'(data), 32'h55);
    chk("t4_break_busy", 32'(busy), 32'd0);
    send_frame(8'h3C, 100, 1'b1, 0, -1);
    idle(20);
    drain("t4");

    // 5: reset during data bit 4 (line low), then a clean frame
    send_frame(8'hA5, 100, 1'b1, 0, 5);
    idle(20);
    drain("t5_abort");
    send_frame(8'h6F, 100, 1'b1, 0, -1);
    idle(20);
    drain("t5");

    // 6: +2% and -2% bit periods
    foreach (pat[i]) begin
      send_frame(pat[i], 102, 1'b1, 0, -1);
      idle(2);
    end
    foreach (pat[i]) begin
      send_frame(pat[i], 98, 1'b1, 0, -1);
      idle(2);
    end
    idle(20);
    drain("t6");

    // 7: random bytes, rates within tolerance, occasional framing errors
    for (int k = 0; k < 16; k++) begin
      logic [7:0] rb;
      bit ok;
      rb = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      send_frame(rb, int'($urandom_range(98, 102)), ok,
                 ok ? 0 : int'($urandom_range(0, 10)), -1);
      idle(ok ? int'($urandom_range(0, 3)) : int'($urandom_range(3, 6)));
    end
    idle(20);
    drain("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
